// File: rtl/trace_dispatcher.sv
// Trace-record dispatcher: decodes trace operations into instruction/data cache
// requests, clear and print strobes, and keeps saturating read/write/fetch statistics.
module trace_dispatcher #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              ic_req,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_done,
    output logic              dc_req,
    output logic [2:0]        dc_op,
    output logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_done,
    output logic              clr_pulse,
    output logic              print_req,
    input  logic              print_done,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  if_cnt,
    output logic              err_op
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        CLEAR   = 3'd3,
        PRINT   = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic              mode_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] ic_addr_q;
    logic [ADDR_W-1:0] dc_addr_q;
    logic [2:0]        dc_op_q;
    logic              err_q;

    logic accept;
    logic op_is_data, op_is_fetch, op_is_clear, op_is_print, op_is_illegal;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        op_is_data    = (cmd_op == 4'd0) || (cmd_op == 4'd1) ||
                        (cmd_op == 4'd3) || (cmd_op == 4'd4);
        op_is_fetch   = (cmd_op == 4'd2);
        op_is_clear   = (cmd_op == 4'd8);
        op_is_print   = (cmd_op == 4'd9);
        op_is_illegal = !(op_is_data || op_is_fetch || op_is_clear || op_is_print);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; done inputs only matter while their request is raised
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_is_data)       state_d = ISSUE_D;
                    else if (op_is_fetch) state_d = ISSUE_I;
                    else if (op_is_clear) state_d = CLEAR;
                    else if (op_is_print) state_d = PRINT;
                    else                  state_d = IDLE;
                end
            end
            ISSUE_I: begin
                if (ic_done) state_d = mode_q ? PRINT : IDLE;
            end
            ISSUE_D: begin
                if (dc_done) state_d = mode_q ? PRINT : IDLE;
            end
            CLEAR: begin
                state_d = IDLE;
            end
            PRINT: begin
                if (print_done) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs; ready is gated by rst_n so it stays low throughout reset
    always_comb begin
        cmd_ready = rst_n && (state_q == IDLE);
        ic_req    = (state_q == ISSUE_I);
        dc_req    = (state_q == ISSUE_D);
        clr_pulse = (state_q == CLEAR);
        print_req = (state_q == PRINT);
    end

    // Latched record; cache-channel address/op persist until the next command for that cache
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            op_q      <= 4'd0;
            ic_addr_q <= '0;
            dc_addr_q <= '0;
            dc_op_q   <= 3'd0;
            err_q     <= 1'b0;
        end else if (accept) begin
            mode_q <= mode;
            op_q   <= cmd_op;
            if (op_is_fetch) begin
                ic_addr_q <= cmd_addr;
            end
            if (op_is_data) begin
                dc_addr_q <= cmd_addr;
                dc_op_q   <= cmd_op[2:0];
            end
            if (op_is_illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ic_addr = ic_addr_q;
    assign dc_addr = dc_addr_q;
    assign dc_op   = dc_op_q;
    assign err_op  = err_q;

    // Statistics: index 0 = reads, 1 = writes, 2 = fetches
    logic [2:0]       cnt_inc;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_vec [3];

    always_comb begin
        cnt_inc[0] = (state_q == ISSUE_D) && dc_done && (op_q == 4'd0);
        cnt_inc[1] = (state_q == ISSUE_D) && dc_done && (op_q == 4'd1);
        cnt_inc[2] = (state_q == ISSUE_I) && ic_done;
        cnt_clr    = (state_q == CLEAR);
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clr) begin
                    cnt_d = '0;
                end else if (cnt_inc[gi] && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_vec[gi] = cnt_q;
        end
    endgenerate

    assign rd_cnt = cnt_vec[0];
    assign wr_cnt = cnt_vec[1];
    assign if_cnt = cnt_vec[2];

endmodule

// File: tb/tb_trace_dispatcher.sv
// Directed bench for trace_dispatcher: a table of trace records with hand-computed
// counter/flag expectations, plus sequences for reset, stray done and saturation.
module tb_trace_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic        dc_req;
    logic [2:0]  dc_op;
    logic [31:0] dc_addr;
    logic        dc_done;
    logic        clr_pulse;
    logic        print_req;
    logic        print_done;
    logic [3:0]  rd_cnt;
    logic [3:0]  wr_cnt;
    logic [3:0]  if_cnt;
    logic        err_op;

    trace_dispatcher #(.ADDR_W(32), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_done   (ic_done),
        .dc_req    (dc_req),
        .dc_op     (dc_op),
        .dc_addr   (dc_addr),
        .dc_done   (dc_done),
        .clr_pulse (clr_pulse),
        .print_req (print_req),
        .print_done(print_done),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .if_cnt    (if_cnt),
        .err_op    (err_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cur_idx = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic        mode;
        int          delay;
        logic [3:0]  e_rd;
        logic [3:0]  e_wr;
        logic [3:0]  e_if;
        logic        e_err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL vec%0d %s: got 0x%0h, expected 0x%0h", cur_idx, name, act, exp);
        end
    endtask

    // Entered and left at a falling edge; drives one record and walks it to completion.
    task automatic apply(input vec_t v);
        logic is_d, is_i, is_p;
        is_d = (v.op == 4'd0) || (v.op == 4'd1) || (v.op == 4'd3) || (v.op == 4'd4);
        is_i = (v.op == 4'd2);
        is_p = (v.op == 4'd9) || ((is_d || is_i) && v.mode);
        chk("cmd_ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_addr  = v.addr;
        mode      = v.mode;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 4'hF;
        cmd_addr  = 32'hDEAD_BEEF;
        mode      = ~v.mode;
        if (is_d || is_i) begin
            for (int c = 0; c < v.delay; c++) begin
                @(negedge clk);
                if (is_d) begin
                    chk("dc_req", dc_req, 1);
                    chk("ic_req_off", ic_req, 0);
                    chk("dc_addr", dc_addr, v.addr);
                    chk("dc_op", dc_op, v.op[2:0]);
                    if (c == v.delay - 1) dc_done = 1'b1;
                end else begin
                    chk("ic_req", ic_req, 1);
                    chk("dc_req_off", dc_req, 0);
                    chk("ic_addr", ic_addr, v.addr);
                    if (c == v.delay - 1) ic_done = 1'b1;
                end
                chk("cmd_ready_busy", cmd_ready, 0);
                @(posedge clk); #1;
                dc_done = 1'b0;
                ic_done = 1'b0;
            end
        end
        if (v.op == 4'd8) begin
            @(negedge clk);
            chk("clr_pulse", clr_pulse, 1);
            @(posedge clk); #1;
        end
        if (is_p) begin
            @(negedge clk);
            chk("print_req", print_req, 1);
            print_done = 1'b1;
            @(posedge clk); #1;
            print_done = 1'b0;
        end
        @(negedge clk);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("reqs_idle", {ic_req, dc_req, print_req, clr_pulse}, 4'b0000);
        chk("rd_cnt", rd_cnt, v.e_rd);
        chk("wr_cnt", wr_cnt, v.e_wr);
        chk("if_cnt", if_cnt, v.e_if);
        chk("err_op", err_op, v.e_err);
        if (is_d) begin
            chk("dc_addr_held", dc_addr, v.addr);
            chk("dc_op_held", dc_op, v.op[2:0]);
        end
        if (is_i) chk("ic_addr_held", ic_addr, v.addr);
        $display("[TB] vec%0d op=%0d addr=0x%0h mode=%0d rd=%0d wr=%0d if=%0d err=%0d",
                 cur_idx, v.op, v.addr, v.mode, rd_cnt, wr_cnt, if_cnt, err_op);
    endtask

    initial begin
        vec_t sv;
        //            op     addr           mode  dly rd     wr     if     err
        vecs[0]  = '{4'd0,  32'h0000_1234, 1'b0, 3, 4'd1, 4'd0, 4'd0, 1'b0};
        vecs[1]  = '{4'd2,  32'h0000_0400, 1'b1, 2, 4'd1, 4'd0, 4'd1, 1'b0};
        vecs[2]  = '{4'd1,  32'hBEEF_0000, 1'b0, 1, 4'd1, 4'd1, 4'd1, 1'b0};
        vecs[3]  = '{4'd3,  32'h0000_0010, 1'b0, 1, 4'd1, 4'd1, 4'd1, 1'b0};
        vecs[4]  = '{4'd4,  32'h0000_0020, 1'b1, 2, 4'd1, 4'd1, 4'd1, 1'b0};
        vecs[5]  = '{4'd0,  32'h0000_0100, 1'b0, 1, 4'd2, 4'd1, 4'd1, 1'b0};
        vecs[6]  = '{4'd0,  32'h0000_0104, 1'b0, 2, 4'd3, 4'd1, 4'd1, 1'b0};
        vecs[7]  = '{4'd0,  32'h0000_0108, 1'b1, 1, 4'd4, 4'd1, 4'd1, 1'b0};
        vecs[8]  = '{4'd0,  32'h0000_010C, 1'b0, 1, 4'd5, 4'd1, 4'd1, 1'b0};
        vecs[9]  = '{4'd7,  32'h0000_0000, 1'b0, 0, 4'd5, 4'd1, 4'd1, 1'b1};
        vecs[10] = '{4'd8,  32'h0000_0000, 1'b0, 0, 4'd0, 4'd0, 4'd0, 1'b1};
        vecs[11] = '{4'd5,  32'h0000_0000, 1'b0, 0, 4'd0, 4'd0, 4'd0, 1'b1};
        vecs[12] = '{4'd0,  32'h0000_0055, 1'b0, 1, 4'd1, 4'd0, 4'd0, 1'b1};
        vecs[13] = '{4'd15, 32'h0000_0099, 1'b0, 0, 4'd1, 4'd0, 4'd0, 1'b1};

        rst_n      = 1'b0;
        mode       = 1'b0;
        cmd_valid  = 1'b0;
        cmd_op     = 4'd0;
        cmd_addr   = 32'd0;
        ic_done    = 1'b0;
        dc_done    = 1'b0;
        print_done = 1'b0;

        #12;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_reqs", {ic_req, dc_req, print_req, clr_pulse}, 4'b0000);
        chk("rst_counters", {rd_cnt, wr_cnt, if_cnt}, 12'h000);
        chk("rst_err", err_op, 0);
        chk("rst_addrs", {ic_addr, dc_addr, 1'b0, dc_op}, 68'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);

        for (int i = 0; i < 14; i++) begin
            cur_idx = i;
            apply(vecs[i]);
        end

        // Stray done pulses while idle must change nothing
        cur_idx = 100;
        dc_done = 1'b1; ic_done = 1'b1; print_done = 1'b1;
        @(posedge clk); #1;
        dc_done = 1'b0; ic_done = 1'b0; print_done = 1'b0;
        @(negedge clk);
        chk("stray_ready", cmd_ready, 1);
        chk("stray_counts", {rd_cnt, wr_cnt, if_cnt}, {4'd1, 4'd0, 4'd0});
        chk("stray_reqs", {ic_req, dc_req, print_req}, 3'b000);

        // Fetch in flight ignores dc_done; ic_done completes it
        cur_idx = 101;
        cmd_valid = 1'b1; cmd_op = 4'd2; cmd_addr = 32'h0000_0800; mode = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("fetch_ic_req", ic_req, 1);
        dc_done = 1'b1;
        @(posedge clk); #1;
        dc_done = 1'b0;
        @(negedge clk);
        chk("fetch_ic_req_held", ic_req, 1);
        chk("fetch_if_cnt_pending", if_cnt, 0);
        ic_done = 1'b1;
        @(posedge clk); #1;
        ic_done = 1'b0;
        @(negedge clk);
        chk("fetch_if_cnt", if_cnt, 1);
        chk("fetch_rd_cnt", rd_cnt, 1);
        chk("fetch_ready", cmd_ready, 1);

        // Print op holds print_req until print_done
        cur_idx = 102;
        cmd_valid = 1'b1; cmd_op = 4'd9; cmd_addr = 32'h0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("print_hold", print_req, 1);
        end
        print_done = 1'b1;
        @(posedge clk); #1;
        print_done = 1'b0;
        @(negedge clk);
        chk("print_released", print_req, 0);
        chk("print_ready", cmd_ready, 1);

        // Clear, then 17 reads on a 4-bit counter
        cur_idx = 10;
        apply(vecs[10]);
        for (int i = 0; i < 17; i++) begin
            cur_idx = 200 + i;
            sv = '{4'd0, 32'h0000_1000 + 32'(i), 1'b0, 1, 4'd0, 4'd0, 4'd0, 1'b1};
            sv.e_rd = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            apply(sv);
        end
        chk("rd_saturated", rd_cnt, 15);

        // Reset asserted in the middle of a data request
        cur_idx = 300;
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_addr = 32'h0000_0ABC; mode = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_dc_req", dc_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_dc_req", dc_req, 0);
        chk("async_ready", cmd_ready, 0);
        chk("async_counts", {rd_cnt, wr_cnt, if_cnt}, 12'h000);
        chk("async_err", err_op, 0);
        chk("async_dc_addr", dc_addr, 0);
        @(negedge clk);
        dc_done = 1'b1;
        @(negedge clk);
        dc_done = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", cmd_ready, 1);
        chk("rel_dc_req", dc_req, 0);
        chk("rel_rd_cnt", rd_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
